// File: rtl/note_recorder.sv
// note_recorder: debounces the note keys and octave switches, quantises each
// held note to a 16th/8th/4th duration and appends its 6-bit code to a
// DEPTH-entry buffer that the player reads back by index.
// Optional feature macro: NOTE_RECORDER_REST_CAPTURE_EN (records 8th rests
// during silent gaps between notes).

// One debounced input: 2-flop synchroniser followed by a stability counter.
module nr_debounce #(
  parameter int CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;

  // Accept the synchronised level once it has differed from db for CYCLES samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_pipe <= '0;
      cnt       <= '0;
      db        <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], raw};
      if (sync_pipe[1] != db) begin
        if (cnt == CNT_LAST) begin
          db  <= sync_pipe[1];
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module note_recorder #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int T16_CYCLES      = 12500000,
  parameter int DEPTH           = 64,
  parameter int AW              = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    keys,
  input  logic          oct_high,
  input  logic          oct_low,
  input  logic          rec_en,
  input  logic          clear,
  input  logic [AW-1:0] rd_addr,
  output logic [5:0]    rd_data,
  output logic [5:0]    live_code,
  output logic          live_valid,
  output logic          wr_pulse,
  output logic [AW:0]   rec_len,
  output logic          full
);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(3*T16_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(3*T16_CYCLES);
  // h < 1.5*T16 expressed in integers: h <= floor(1.5*T16 - 0.5)
  localparam logic [HW-1:0] HOLD_16  = HW'((3*T16_CYCLES + 1) / 2);
  localparam logic [LW-1:0] LEN_LAST = LW'(DEPTH - 1);

  localparam logic [1:0] OCT_MID = 2'd0, OCT_LOW = 2'd1, OCT_HIGH = 2'd2;
  localparam logic [1:0] DUR_8 = 2'd0, DUR_4 = 2'd1, DUR_16 = 2'd2;

  typedef enum logic [2:0] {IDLE, ARMED, PRESSED, COMMIT, FULL} state_t;

  // Code = 21*octave + 7*duration + pitch, matching the player's note table.
  function automatic logic [5:0] enc(input logic [1:0] oct, input logic [1:0] dur,
                                     input logic [2:0] p);
    enc = 6'(oct) * 6'd21 + 6'(dur) * 6'd7 + 6'(p);
  endfunction

  // ---------------- debounce: keys[6:0], oct_high, oct_low ----------------
  logic [8:0] raw_vec, db_vec;
  assign raw_vec = {keys, oct_high, oct_low};

  nr_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [8:0] (
    .clk (clk),
    .rst (rst),
    .raw (raw_vec),
    .db  (db_vec)
  );

  // ---------------- live decode ----------------
  logic [6:0] dkeys;
  logic       key_ok;
  logic [2:0] live_p;
  logic [1:0] live_oct;

  assign dkeys  = db_vec[8:2];
  assign key_ok = $onehot(dkeys);
  assign live_oct = (db_vec[1] & ~db_vec[0]) ? OCT_HIGH :
                    (db_vec[0] & ~db_vec[1]) ? OCT_LOW  : OCT_MID;

  // bit6 = do (p=1) ... bit0 = si (p=7); only meaningful when key_ok.
  always_comb begin
    live_p = '0;
    for (int i = 0; i < 7; i++)
      if (dkeys[i]) live_p = 3'(7 - i);
  end

  assign live_valid = key_ok;
  assign live_code  = key_ok ? enc(live_oct, DUR_8, live_p) : 6'd0;

  // ---------------- recorder FSM ----------------
  state_t        state;
  logic [2:0]    cur_p;
  logic [1:0]    cur_oct;
  logic [HW-1:0] hold;
  logic [1:0]    hold_dur;
  logic [5:0]    commit_code;
  logic          new_note;
  logic          wr_en;

`ifdef NOTE_RECORDER_REST_CAPTURE_EN
  localparam int SW = (2*T16_CYCLES > 1) ? $clog2(2*T16_CYCLES) : 1;
  localparam logic [SW-1:0] SIL_LAST = SW'(2*T16_CYCLES - 1);
  logic [SW-1:0] sil_cnt;
  logic [2:0]    rest_n;
`endif

  // Quantise the hold time of the current note.
  always_comb begin
    if (hold < HOLD_16)       hold_dur = DUR_16;
    else if (hold < HOLD_MAX) hold_dur = DUR_8;
    else                      hold_dur = DUR_4;
  end

  assign new_note = key_ok && ((live_p != cur_p) || (live_oct != cur_oct));
  // clear wins over a pending commit.
  assign wr_en    = (state == COMMIT) && !clear;

  // State, hold timing, record length and write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_p       <= '0;
      cur_oct     <= '0;
      hold        <= '0;
      commit_code <= '0;
      rec_len     <= '0;
      full        <= 1'b0;
      wr_pulse    <= 1'b0;
`ifdef NOTE_RECORDER_REST_CAPTURE_EN
      sil_cnt     <= '0;
      rest_n      <= '0;
`endif
    end else begin
      wr_pulse <= 1'b0;
      if (clear) begin
        rec_len <= '0;
        full    <= 1'b0;
        state   <= rec_en ? ARMED : IDLE;
`ifdef NOTE_RECORDER_REST_CAPTURE_EN
        sil_cnt <= '0;
        rest_n  <= '0;
`endif
      end else begin
        case (state)
          IDLE: if (rec_en) state <= ARMED;
          ARMED: begin
            if (!rec_en) begin
              state <= IDLE;
            end else if (key_ok) begin
              state   <= PRESSED;
              cur_p   <= live_p;
              cur_oct <= live_oct;
              hold    <= '0;
`ifdef NOTE_RECORDER_REST_CAPTURE_EN
              sil_cnt <= '0;
              rest_n  <= '0;
            end else if (rec_len != '0 && rest_n != 3'd4) begin
              if (sil_cnt == SIL_LAST) begin
                sil_cnt     <= '0;
                rest_n      <= rest_n + 1'b1;
                commit_code <= 6'd0;
                state       <= COMMIT;
              end else begin
                sil_cnt <= sil_cnt + 1'b1;
              end
`else
              // silent gaps between notes are not recorded
`endif
            end
          end
          PRESSED: begin
            if (!rec_en) begin
              state <= IDLE;
            end else if (!key_ok || new_note) begin
              commit_code <= enc(cur_oct, hold_dur, cur_p);
              state       <= COMMIT;
            end else if (hold != HOLD_MAX) begin
              hold <= hold + 1'b1;
            end
          end
          COMMIT: begin
            rec_len  <= rec_len + 1'b1;
            wr_pulse <= 1'b1;
            if (rec_len == LEN_LAST) begin
              full  <= 1'b1;
              state <= FULL;
            end else if (key_ok && rec_en) begin
              state   <= PRESSED;
              cur_p   <= live_p;
              cur_oct <= live_oct;
              hold    <= '0;
`ifdef NOTE_RECORDER_REST_CAPTURE_EN
              sil_cnt <= '0;
              rest_n  <= '0;
`endif
            end else begin
              state <= ARMED;
            end
          end
          FULL:    state <= FULL;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------- note buffer ----------------
  logic [5:0] mem [DEPTH];

  // Buffer write; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[rec_len[AW-1:0]] <= commit_code;
  end

  // Registered read; unrecorded slots read as a rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= (LW'(rd_addr) < rec_len) ? mem[rd_addr] : 6'd0;
  end
endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Upstream stage of the song player: captures live note-key presses, debounces them and encodes each note into the player's 6-bit note code (pitch, octave and duration).
- Stores the codes in an internal buffer. The player reads the buffer back by index, the same way it indexes a packed melody.
- Also presents the current live note, so the board can sound and light it during free play.

Parameters:
- DEBOUNCE_CYCLES, 2000000: cycles a raw input must stay stable before it is accepted (20 ms at 100 MHz).
- T16_CYCLES, 12500000: length of one 16th-note slot in cycles (0.125 s).
- DEPTH, 64: buffer capacity in notes.
- AW, 6: address width, log2(DEPTH).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- keys  in  7  raw note switches; bit6 = do … bit0 = si.
- oct_high  in  1  raw high-octave switch.
- oct_low  in  1  raw low-octave switch.
- rec_en  in  1  recording enable (level).
- clear  in  1  synchronous buffer clear (level).
- rd_addr  in  AW  player read index.
- rd_data  out  6  note code at rd_addr; registered, 1-cycle latency.
- live_code  out  6  8th-length code of the currently held note; 0 when no note is held.
- live_valid  out  1  a single valid key is held (debounced).
- wr_pulse  out  1  one-cycle strobe on each buffer write.
- rec_len  out  AW+1  number of stored notes, 0..DEPTH.
- full  out  1  rec_len == DEPTH.

Behaviour:
- Reset values: all outputs 0, buffer contents don't-care, state IDLE, all counters 0.
- Debounce:
  - Each of the 9 raw inputs has its own counter and is accepted after DEBOUNCE_CYCLES stable cycles.
  - Total latency from raw edge to debounced edge is DEBOUNCE_CYCLES+2 cycles, including a 2-flop synchroniser.
- Key decode:
  - Exactly one debounced key high gives a valid pitch p = 1..7 (do..si). Zero or more than one key high counts as no key.
  - Octave selection:
    - oct_high alone → high.
    - oct_low alone → low.
    - Neither, or both → middle.
- Code map by octave and duration; p is added to the base:
  - Middle: 8th base 0, 4th base 7, 16th base 14.
  - Low: 8th base 21, 4th base 28, 16th base 35.
  - High: 8th base 42, 4th base 49, 16th base 56.
  - Example: high re 16th = 58.
- live_code always uses the 8th-note code of the held note.
- Duration is quantised from hold time h, measured from debounced press to release or key change:
  - h < 1.5·T16 → 16th.
  - h < 3·T16 → 8th.
  - Otherwise → 4th.
  - The hold counter saturates at 3·T16.
- FSM:
  - IDLE: rec_en=1 → ARMED.
  - ARMED: a valid key appears → PRESSED; latch pitch and octave, clear the hold counter. rec_en=0 → IDLE.
  - PRESSED:
    - Release → COMMIT.
    - A different valid key (pitch or octave) → COMMIT; the new note then starts in PRESSED on the next cycle.
    - rec_en=0 → IDLE; the held note is discarded.
  - COMMIT (1 cycle):
    - Write the code at address rec_len, increment rec_len, pulse wr_pulse.
    - If rec_len becomes DEPTH → FULL; otherwise → ARMED, or → PRESSED if a new key is already held.
  - FULL: all writes ignored, full=1; only clear leaves this state.
- clear:
  - rec_len ← 0, full ← 0.
  - State ← ARMED if rec_en=1, otherwise IDLE.
  - Beats a COMMIT in the same cycle: no write occurs.
  - Buffer data is not zeroed.
- rd_data:
  - Reading at or beyond rec_len returns 0 (rest).
  - A read and a write to the same address in one cycle return the old data.
- Reset asserted mid-press returns to IDLE immediately; no write occurs.

Optional Feature:
- Macro: NOTE_RECORDER_REST_CAPTURE_EN.
- Defined:
  - In ARMED with rec_len > 0, each full 2·T16 cycles of silence writes rest code 0 (8th rest), with the normal wr_pulse and full handling.
  - At most 4 consecutive rests are written per gap.
  - The silence counter resets on any key press.
- Undefined: gaps between notes are not recorded; the rest counter logic is absent.

Test Plan:
- Sim params DEBOUNCE_CYCLES=4, T16_CYCLES=10, DEPTH=4 for all scenarios below.
- Basic capture: rec_en=1; hold keys=7'b0100000 (re), middle octave, for 20 cycles → one wr_pulse, rec_len=1; rd_addr=0 gives rd_data=2 one cycle later.
- Durations: hold do/oct_high for 8, 20 and 40 cycles → codes 57, 43, 50 at addresses 0..2.
- Chord and bounce: keys=7'b1100000 held → no write, live_valid=0. Toggling do for less than 4 cycles → no write.
- Full: record 5 notes → rec_len=4, full=1, fifth note not written. clear asserted → rec_len=0, full=0, next note written at address 0.
- Abort: rec_en dropped mid-hold → no wr_pulse. rst mid-hold → all outputs 0.
- Rest capture (macro defined): one note, then 45 silent cycles → rest codes written at addresses 1 and 2, rd_data=0 at both.
